fetch_unit: RTL and testbench

//  Instruction fetch stage, directly upstream of decode / immediate generation.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int FU_AWIDTH = 32;
    localparam int FU_DWIDTH = 32;
    localparam logic [FU_AWIDTH-1:0] FU_BASEADDR = 32'h0100_0000;

    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;

    typedef struct packed {
        logic [FU_AWIDTH-1:0] pc;
        logic [FU_DWIDTH-1:0] insn;
    } fetch_entry_t;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [FU_DWIDTH-1:0] insn);
        return insn[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; the head is read directly from
// storage, so a pushed entry appears on the head one cycle later.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_W = DEPTH[CW-1:0];

    fetch_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (count_q == DEPTH_W);
        empty    = (count_q == '0);
        count    = count_q;
        head     = mem_q[rd_ptr_q];
        do_pop   = pop && !empty;
        // a full queue may still accept when the head leaves in the same cycle
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem reads, in-order instruction
// queue toward decode, and redirect flush with stale-response dropping.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int AWIDTH = FU_AWIDTH,
    parameter int DWIDTH = FU_DWIDTH,
    parameter int DEPTH  = 2,
    parameter logic [AWIDTH-1:0] BASEADDR = FU_BASEADDR
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [AWIDTH-1:0] dec_pc_o,
    output logic [DWIDTH-1:0] dec_insn_o,
    output logic [6:0]        dec_opcode_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW:0]       credit_used;
    logic              issue, rsp, rsp_keep, deq;

    logic              q_full, q_empty, tag_full, tag_empty;
    logic [CW-1:0]     q_count, tag_count;
    fetch_entry_t      q_head, tag_head, q_push_data, tag_push_data;

    always_comb begin
        credit_used      = {1'b0, q_count} + {1'b0, outstanding_q};
        imem_req_valid_o = !reset && !redirect_i && (credit_used < DEPTH_W);
        imem_addr_o      = pc_q;
        issue            = imem_req_valid_o && imem_req_ready_i;
        rsp              = imem_rsp_valid_i;
        rsp_keep         = rsp && (drop_q == '0) && !redirect_i;
        deq              = !q_empty && dec_ready_i && !redirect_i;

        tag_push_data.pc   = pc_q;
        tag_push_data.insn = '0;
        q_push_data.pc     = tag_head.pc;
        q_push_data.insn   = imem_rsp_data_i;

        dec_valid_o  = !q_empty;
        dec_pc_o     = q_empty ? '0 : q_head.pc;
        dec_insn_o   = q_empty ? '0 : q_head.insn;
        dec_opcode_o = opcode_of(dec_insn_o);
    end

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect_i) begin
            // every read still in flight, minus one returning now, is stale
            pc_d          = redirect_pc_i & ~AWIDTH'(3);
            outstanding_d = outstanding_q - CW'(rsp);
            drop_d        = outstanding_q - CW'(rsp);
        end else begin
            if (issue) pc_d = pc_q + AWIDTH'(4);
            outstanding_d = outstanding_q + CW'(issue) - CW'(rsp);
            if (rsp && drop_q != '0) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= BASEADDR;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Tags track every in-flight read, stale or not, so they are never flushed.
    fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (issue),
        .push_data (tag_push_data),
        .pop       (rsp),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count),
        .head      (tag_head)
    );

    fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_insn_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_i),
        .push      (rsp_keep),
        .push_data (q_push_data),
        .pop       (deq),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head      (q_head)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rsp_valid_i && outstanding_q == '0));
            assert (tag_count == outstanding_q);
            assert (drop_q <= outstanding_q);
            assert (!(issue && tag_full));
            assert (!(rsp_keep && q_full && !deq));
            assert (tag_empty || tag_head.insn == '0);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomised bench for fetch_unit with an in-order memory model
// and a sequential-PC / redirect reference trace.
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_insn_o;
    logic [6:0]  dec_opcode_o;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .dec_valid_o      (dec_valid_o),
        .dec_ready_i      (dec_ready_i),
        .dec_pc_o         (dec_pc_o),
        .dec_insn_o       (dec_insn_o),
        .dec_opcode_o     (dec_opcode_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc;
    int          lat_lo, lat_hi;
    int          m_cnt, m_drop;
    logic [31:0] exp_req_pc, exp_dec_pc;
    int          n_chk, n_bad;
    int          n_issue, n_deq;
    logic        first_req_seen, first_dec_seen, seen_zero;
    logic [31:0] first_req_addr, first_dec_pc;

    function automatic logic [31:0] mkinsn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_cnt      = 0;
        m_drop     = 0;
        exp_req_pc = BASE;
        exp_dec_pc = BASE;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        dec_ready_i      = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("rst_req_valid", imem_req_valid_o, 0);
        chk("rst_dec_valid", dec_valid_o, 0);
        chk("rst_dec_pc", dec_pc_o, 0);
        chk("rst_dec_insn", dec_insn_o, 0);
        chk("rst_pc", dut.pc_q, BASE);
        chk("rst_outstanding", dut.outstanding_q, 0);
        chk("rst_drop", dut.drop_q, 0);
        reset = 1'b0;
        model_clear();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic cycle(input logic redir, input logic [31:0] rpc,
                         input logic rreq_ready, input logic rdec_ready);
        logic        rsp, exp_rv, consume, keep;
        logic [31:0] raddr, einsn;
        rsp   = 1'b0;
        raddr = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rsp   = 1'b1;
            raddr = mq[0].addr;
        end
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = rsp ? mkinsn(raddr) : 32'h0;
        redirect_i       = redir;
        redirect_pc_i    = rpc;
        imem_req_ready_i = rreq_ready;
        dec_ready_i      = rdec_ready;
        #1;
        exp_rv = !redir && (m_cnt + mq.size() < DEPTH);
        chk("req_valid", imem_req_valid_o, exp_rv);
        if (exp_rv) chk("req_addr", imem_addr_o, exp_req_pc);
        chk("dec_valid", dec_valid_o, m_cnt != 0);
        if (m_cnt != 0) begin
            einsn = mkinsn(exp_dec_pc);
            chk("dec_pc", dec_pc_o, exp_dec_pc);
            chk("dec_insn", dec_insn_o, einsn);
            chk("dec_opcode", dec_opcode_o, einsn[6:0]);
        end else begin
            chk("empty_pc", dec_pc_o, 0);
            chk("empty_insn", dec_insn_o, 0);
        end
        if (imem_req_valid_o && rreq_ready) begin
            n_issue++;
            if (!first_req_seen) begin
                first_req_seen = 1'b1;
                first_req_addr = imem_addr_o;
            end
        end
        consume = (m_cnt != 0) && rdec_ready && !redir;
        if (consume) begin
            n_deq++;
            if (dec_pc_o == 32'h0) seen_zero = 1'b1;
            if (!first_dec_seen) begin
                first_dec_seen = 1'b1;
                first_dec_pc   = dec_pc_o;
            end
        end
        if (rsp) void'(mq.pop_front());
        keep = rsp && m_drop == 0 && !redir;
        if (redir) begin
            m_drop     = mq.size();
            m_cnt      = 0;
            exp_req_pc = rpc & 32'hFFFF_FFFC;
            exp_dec_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (rsp && m_drop != 0) m_drop--;
            if (consume) begin
                m_cnt--;
                exp_dec_pc = exp_dec_pc + 32'd4;
            end
            if (keep) m_cnt++;
            if (exp_rv && rreq_ready) begin
                mq.push_back('{addr: exp_req_pc, due: cyc + $urandom_range(lat_hi, lat_lo)});
                exp_req_pc = exp_req_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("outstanding", dut.outstanding_q, mq.size());
        chk("drop", dut.drop_q, m_drop);
    endtask

    logic [31:0] t5_pc;
    int          exp_drop4;
    logic        found;

    initial begin
        cyc = 0; n_chk = 0; n_bad = 0; n_issue = 0; n_deq = 0;
        lat_lo = 1; lat_hi = 1;
        first_req_seen = 1'b0; first_dec_seen = 1'b0; seen_zero = 1'b0;
        first_req_addr = '0; first_dec_pc = '0;
        model_clear();

        // 1: streaming from reset, latency 1
        do_reset();
        first_dec_seen = 1'b0;
        first_req_seen = 1'b0;
        n_deq = 0;
        for (int i = 0; i < 30; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t1_first_req", first_req_addr, BASE);
        chk("t1_first_dec", first_dec_pc, BASE);
        chk("t1_progress", n_deq >= 15, 1);

        // 2: decode stalled, latency 3 -> exactly DEPTH requests
        do_reset();
        lat_lo = 3; lat_hi = 3;
        n_issue = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t2_issued", n_issue, DEPTH);
        n_deq = 0;
        for (int i = 0; i < 30; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t2_resume", n_deq >= 5, 1);

        // 3: redirect with two reads outstanding
        do_reset();
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t3_out2", dut.outstanding_q, 2);
        first_req_seen = 1'b0;
        first_dec_seen = 1'b0;
        cycle(1'b1, 32'h0100_0103, 1'b1, 1'b1);
        chk("t3_drop2", dut.drop_q, 2);
        for (int i = 0; i < 20 && !first_dec_seen; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t3_dec_seen", first_dec_seen, 1);
        chk("t3_first_req", first_req_addr, 32'h0100_0100);
        chk("t3_first_dec", first_dec_pc, 32'h0100_0100);

        // 4: redirect coincident with a response and a dequeue
        lat_lo = 1; lat_hi = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() > 0 && mq[0].due <= cyc && m_cnt > 0) found = 1'b1;
            else cycle(1'b0, 32'h0, 1'b1, 1'b1);
        end
        chk("t4_setup", found, 1);
        exp_drop4 = mq.size() - 1;
        cycle(1'b1, 32'h0100_0200, 1'b1, 1'b1);
        #1;
        chk("t4_empty", dec_valid_o, 0);
        chk("t4_drop", dut.drop_q, exp_drop4);
        chk("t4_out", dut.outstanding_q, exp_drop4);

        // 5: memory not ready -> address and PC hold
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        t5_pc = exp_req_pc;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            chk("t5_pc", dut.pc_q, t5_pc);
            chk("t5_out", dut.outstanding_q, 0);
        end
        chk("t5_addr", imem_addr_o, t5_pc);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // PC wrap past the top of the address space
        seen_zero = 1'b0;
        cycle(1'b1, 32'hFFFF_FFF9, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_seen_zero", seen_zero, 1);

        // reset while reads are outstanding
        lat_lo = 3; lat_hi = 3;
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        do_reset();
        lat_lo = 1; lat_hi = 1;
        first_dec_seen = 1'b0;
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("rst_mid_first_dec", first_dec_pc, BASE);

        // 6: random ready, latency and redirects
        lat_lo = 1; lat_hi = 4;
        n_deq = 0;
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(15) == 0,
                  32'h0200_0000 + 32'($urandom_range(1023)),
                  $urandom_range(3) != 0,
                  $urandom_range(3) != 0);
        end
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_progress", n_deq >= 50, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
